// File: rtl/register_arbiter.sv
// register_arbiter: round-robin arbiter giving four requesters write access
// to one shared 16-bit Register. Each transaction is IDLE -> WRITE -> ACK,
// so a continuously requesting set of clients gets one write every 3 cycles.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting; winner index and its data slice are latched on any request
// WRITE | reg_load_o pulses with the latched data for one cycle
// ACK   | gnt_o pulses to the winner, rdata_o shows the Register, ptr advances
module register_arbiter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  req_i,
  input  logic [63:0] data_i,
  input  logic [15:0] reg_q_i,
  output logic [15:0] reg_in_o,
  output logic        reg_load_o,
  output logic [3:0]  gnt_o,
  output logic [15:0] rdata_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    ACK   = 2'b10
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  ptr;
  logic [1:0]  winner;
  logic [1:0]  pick;
  logic [15:0] data_lat;
  logic        start;

  // First set request bit at or after base, wrapping 3 -> 0. The loop walks
  // from the farthest candidate to the nearest so the nearest one wins.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] base);
    logic [1:0] idx;
    rr_pick = base;
    for (int i = 3; i >= 0; i--) begin
      idx = base + 2'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  assign pick  = rr_pick(req_i, ptr);
  assign start = (state == IDLE) && (req_i != 4'b0000);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Winner and data are captured only in IDLE so late input changes cannot
  // disturb the transaction in flight; the pointer moves past the winner on ACK.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr      <= 2'd0;
      winner   <= 2'd0;
      data_lat <= 16'h0000;
    end else begin
      if (start) begin
        winner   <= pick;
        data_lat <= data_i[{pick, 4'b0000} +: 16];
      end
      if (state == ACK) ptr <= winner + 2'd1;
    end
  end

  // Next state and outputs. rst_i masks every strobe combinationally so a
  // reset landing in WRITE or ACK neither writes the Register nor grants.
  always_comb begin
    state_nxt  = state;
    reg_in_o   = data_lat;
    reg_load_o = 1'b0;
    gnt_o      = 4'b0000;
    rdata_o    = 16'h0000;
    busy_o     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = WRITE;
      end
      WRITE: begin
        state_nxt  = ACK;
        reg_load_o = !rst_i;
        busy_o     = !rst_i;
      end
      ACK: begin
        state_nxt = IDLE;
        busy_o    = !rst_i;
        if (!rst_i) begin
          gnt_o   = 4'b0001 << winner;
          rdata_o = reg_q_i;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_register_arbiter.sv
// Bench for register_arbiter: directed vector table, hand sequences for
// round-robin order and idle behaviour, then random traffic against a
// transaction-level reference model.
module tb_register_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [3:0]  req_i;
  logic [63:0] data_i;
  logic [15:0] reg_q = 16'h0000;
  logic [15:0] reg_in;
  logic        reg_load;
  logic [3:0]  gnt;
  logic [15:0] rdata;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  register_arbiter dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .req_i      (req_i),
    .data_i     (data_i),
    .reg_q_i    (reg_q),
    .reg_in_o   (reg_in),
    .reg_load_o (reg_load),
    .gnt_o      (gnt),
    .rdata_o    (rdata),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  // The shared Register the arbiter drives.
  always @(posedge clk) if (reg_load) reg_q <= reg_in;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [63:0] data;
    logic        load;
    logic [15:0] in;
    logic [3:0]  gnt;
    logic [15:0] rd;
    logic        busy;
  } vec_t;

  vec_t tbl[29];

  function automatic vec_t mk(input logic r, input logic [3:0] q, input logic [63:0] d,
                              input logic l, input logic [15:0] i, input logic [3:0] g,
                              input logic [15:0] rd, input logic b);
    vec_t v;
    v.rst = r; v.req = q; v.data = d; v.load = l;
    v.in = i; v.gnt = g; v.rd = rd; v.busy = b;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i  = 1'b1;
    req_i  = 4'h0;
    data_i = 64'h0;
    tick();
    rst_i  = 1'b0;
  endtask

  // Reference model: a transaction is scheduled as absolute cycle numbers.
  int          m_cyc;
  int          t_load;
  int          t_gnt;
  int          m_ptr;
  int          m_win;
  logic [15:0] m_in;

  int          gi[$];
  int          gc[$];
  logic [15:0] lv[$];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //              rst  req   data                    load in       gnt   rd       busy
    tbl[0]  = mk(1, 4'h0, 64'h0,                    0, 16'h0000, 4'h0, 16'h0000, 0);
    tbl[1]  = mk(0, 4'h1, 64'h0000_0000_0000_1234, 0, 16'h0000, 4'h0, 16'h0000, 0);
    tbl[2]  = mk(0, 4'h1, 64'h0000_0000_0000_1234, 1, 16'h1234, 4'h0, 16'h0000, 1);
    tbl[3]  = mk(0, 4'h1, 64'h0000_0000_0000_1234, 0, 16'h1234, 4'h1, 16'h1234, 1);
    tbl[4]  = mk(0, 4'h0, 64'h0,                    0, 16'h1234, 4'h0, 16'h0000, 0);
    tbl[5]  = mk(0, 4'h2, 64'h0000_0000_0055_0000, 0, 16'h1234, 4'h0, 16'h0000, 0);
    tbl[6]  = mk(0, 4'h2, 64'h0000_0000_00AA_0000, 1, 16'h0055, 4'h0, 16'h0000, 1);
    tbl[7]  = mk(0, 4'h0, 64'h0000_0000_00AA_0000, 0, 16'h0055, 4'h2, 16'h0055, 1);
    tbl[8]  = mk(0, 4'h0, 64'h0,                    0, 16'h0055, 4'h0, 16'h0000, 0);
    tbl[9]  = mk(0, 4'h8, 64'h3333_0000_0000_0000, 0, 16'h0055, 4'h0, 16'h0000, 0);
    tbl[10] = mk(0, 4'h9, 64'h3333_0000_0000_0F0F, 1, 16'h3333, 4'h0, 16'h0000, 1);
    tbl[11] = mk(0, 4'h9, 64'h3333_0000_0000_0F0F, 0, 16'h3333, 4'h8, 16'h3333, 1);
    tbl[12] = mk(0, 4'h9, 64'h3333_0000_0000_0F0F, 0, 16'h3333, 4'h0, 16'h0000, 0);
    tbl[13] = mk(0, 4'h1, 64'h3333_0000_0000_0F0F, 1, 16'h0F0F, 4'h0, 16'h0000, 1);
    tbl[14] = mk(0, 4'h0, 64'h0,                    0, 16'h0F0F, 4'h1, 16'h0F0F, 1);
    tbl[15] = mk(0, 4'h0, 64'h0,                    0, 16'h0F0F, 4'h0, 16'h0000, 0);
    tbl[16] = mk(0, 4'h2, 64'h0000_0000_1111_0000, 0, 16'h0F0F, 4'h0, 16'h0000, 0);
    tbl[17] = mk(0, 4'h2, 64'h0000_0000_1111_0000, 1, 16'h1111, 4'h0, 16'h0000, 1);
    tbl[18] = mk(1, 4'h2, 64'h0000_0000_1111_0000, 0, 16'h1111, 4'h0, 16'h0000, 0);
    tbl[19] = mk(0, 4'h4, 64'h0000_2222_0000_0000, 0, 16'h0000, 4'h0, 16'h0000, 0);
    tbl[20] = mk(0, 4'h4, 64'h0000_2222_0000_0000, 1, 16'h2222, 4'h0, 16'h0000, 1);
    tbl[21] = mk(0, 4'h0, 64'h0,                    0, 16'h2222, 4'h4, 16'h2222, 1);
    tbl[22] = mk(0, 4'h9, 64'hBBBB_0000_0000_AAAA, 0, 16'h2222, 4'h0, 16'h0000, 0);
    tbl[23] = mk(0, 4'h9, 64'hBBBB_0000_0000_AAAA, 1, 16'hBBBB, 4'h0, 16'h0000, 1);
    tbl[24] = mk(0, 4'h9, 64'hBBBB_0000_0000_AAAA, 0, 16'hBBBB, 4'h8, 16'hBBBB, 1);
    tbl[25] = mk(0, 4'h0, 64'h0,                    0, 16'hBBBB, 4'h0, 16'h0000, 0);
    tbl[26] = mk(0, 4'h4, 64'h0000_5A5A_0000_0000, 0, 16'hBBBB, 4'h0, 16'h0000, 0);
    tbl[27] = mk(1, 4'h4, 64'h0000_5A5A_0000_0000, 0, 16'h5A5A, 4'h0, 16'h0000, 0);
    tbl[28] = mk(0, 4'h0, 64'h0,                    0, 16'h0000, 4'h0, 16'h0000, 0);

    rst_i  = 1'b1;
    req_i  = 4'h0;
    data_i = 64'h0;
    tick();
    tick();

    // Directed vectors: single write, late data change, pointer wrap,
    // reset in ACK and in WRITE.
    for (int i = 0; i < 29; i++) begin
      rst_i  = tbl[i].rst;
      req_i  = tbl[i].req;
      data_i = tbl[i].data;
      #1;
      chk($sformatf("vec%0d_load", i), 64'(reg_load), 64'(tbl[i].load));
      chk($sformatf("vec%0d_in", i),   64'(reg_in),   64'(tbl[i].in));
      chk($sformatf("vec%0d_gnt", i),  64'(gnt),      64'(tbl[i].gnt));
      chk($sformatf("vec%0d_rdata", i), 64'(rdata),   64'(tbl[i].rd));
      chk($sformatf("vec%0d_busy", i), 64'(busy),     64'(tbl[i].busy));
      tick();
    end
    chk("abort_no_write", 64'(reg_q), 64'hBBBB);

    // All four requesting continuously.
    do_reset();
    req_i  = 4'hF;
    data_i = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    for (int c = 0; c < 16; c++) begin
      #1;
      if (gnt != 4'h0) begin
        chk($sformatf("rr_onehot_c%0d", c), 64'($onehot(gnt)), 64'd1);
        for (int n = 0; n < 4; n++) if (gnt[n]) gi.push_back(n);
        gc.push_back(c);
      end
      if (reg_load) lv.push_back(reg_in);
      tick();
    end
    chk("rr_grant_count", 64'(gi.size()), 64'd5);
    chk("rr_load_count", 64'(lv.size()), 64'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < gi.size()) begin
        chk($sformatf("rr_grant%0d_idx", k), 64'(gi[k]), 64'(k % 4));
        chk($sformatf("rr_grant%0d_cycle", k), 64'(gc[k]), 64'(2 + 3 * k));
      end
      if (k < lv.size()) chk($sformatf("rr_load%0d", k), 64'(lv[k]), 64'(16'hA000 + 16'(k % 4)));
    end

    // One write, then ten idle cycles.
    do_reset();
    req_i  = 4'h4;
    data_i = 64'h0000_C0DE_0000_0000;
    tick();
    tick();
    req_i  = 4'h0;
    data_i = 64'h0;
    tick();
    for (int c = 0; c < 10; c++) begin
      #1;
      chk($sformatf("idle%0d_load", c), 64'(reg_load), 64'd0);
      chk($sformatf("idle%0d_gnt", c),  64'(gnt),      64'd0);
      chk($sformatf("idle%0d_busy", c), 64'(busy),     64'd0);
      chk($sformatf("idle%0d_in", c),   64'(reg_in),   64'hC0DE);
      tick();
    end
    chk("idle_reg_value", 64'(reg_q), 64'hC0DE);

    // Random traffic against the reference model.
    do_reset();
    t_load = -10;
    t_gnt  = -10;
    m_ptr  = 0;
    m_win  = 0;
    m_in   = 16'h0000;
    for (m_cyc = 0; m_cyc < 300; m_cyc++) begin
      logic        idle;
      logic        e_load;
      logic        e_busy;
      logic [3:0]  e_gnt;
      logic [15:0] e_rd;
      rst_i = (m_cyc > 5) && ($urandom_range(0, 39) == 0);
      req_i = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) req_i = 4'h0;
      data_i = {$urandom, $urandom};
      #1;
      idle   = !(m_cyc >= t_load && m_cyc <= t_gnt);
      e_load = !rst_i && (m_cyc == t_load);
      e_busy = !rst_i && !idle;
      e_gnt  = (!rst_i && m_cyc == t_gnt) ? 4'(1 << m_win) : 4'h0;
      e_rd   = (!rst_i && m_cyc == t_gnt) ? m_in : 16'h0000;
      chk($sformatf("rnd%0d_load", m_cyc),  64'(reg_load), 64'(e_load));
      chk($sformatf("rnd%0d_in", m_cyc),    64'(reg_in),   64'(m_in));
      chk($sformatf("rnd%0d_gnt", m_cyc),   64'(gnt),      64'(e_gnt));
      chk($sformatf("rnd%0d_rdata", m_cyc), 64'(rdata),    64'(e_rd));
      chk($sformatf("rnd%0d_busy", m_cyc),  64'(busy),     64'(e_busy));
      if (rst_i) begin
        t_load = -10;
        t_gnt  = -10;
        m_ptr  = 0;
        m_win  = 0;
        m_in   = 16'h0000;
      end else if (m_cyc == t_gnt) begin
        m_ptr = (m_win + 1) % 4;
      end else if (idle && req_i != 4'h0) begin
        for (int k = 3; k >= 0; k--) if (req_i[(m_ptr + k) % 4]) m_win = (m_ptr + k) % 4;
        m_in   = data_i[16 * m_win +: 16];
        t_load = m_cyc + 1;
        t_gnt  = m_cyc + 2;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_arbiter.md
REGISTER_ARBITER -- requirements
Module: register_arbiter

Interface
REQ-001 Parameters: none; data width fixed at 16, requester count fixed at 4.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 req_i  input  4  write request per requester; bit n = requester n.
REQ-005 data_i  input  64  write data; requester n at bits [16n+15:16n].
REQ-006 reg_q_i  input  16  current output of the shared 16-bit Register.
REQ-007 reg_in_o  output  16  data to shared Register in_i.
REQ-008 reg_load_o  output  1  load strobe to shared Register load_i.
REQ-009 gnt_o  output  4  one-hot completion pulse to the winning requester.
REQ-010 rdata_o  output  16  read-back of the Register value, valid when any gnt_o bit is high.
REQ-011 busy_o  output  1  high while a transaction is in progress (state not IDLE).

Function
REQ-012 FSM states: IDLE, WRITE, ACK; encoding is an implementation choice.
REQ-013 IDLE: if req_i != 0, latch the winner index and its data_i slice, then go to WRITE; otherwise stay in IDLE.
REQ-014 Arbitration: round-robin; search starts at pointer ptr and wraps 3->0; first set req_i bit wins.
REQ-015 WRITE: reg_load_o = 1 and reg_in_o = latched data for exactly one cycle; next state ACK.
REQ-016 ACK: gnt_o[winner] = 1 for exactly one cycle; rdata_o = reg_q_i; ptr <= (winner+1) mod 4; next state IDLE.
REQ-017 Latency: request sampled at edge k -> reg_load_o high in cycle k+1 -> gnt_o in cycle k+2; maximum throughput is one write per 3 cycles.
REQ-018 Outside WRITE: reg_load_o = 0; reg_in_o holds the last latched data (0 after reset).
REQ-019 Outside ACK: gnt_o = 0 and rdata_o = 0.
REQ-020 Data and winner are latched only in IDLE; changes to req_i or data_i during WRITE or ACK have no effect on the transaction in flight.
REQ-021 If the requester deasserts req_i after being latched, the write still completes and gnt_o still pulses.
REQ-022 Requester protocol: hold req_i until the gnt_o pulse; keeping req_i high after gnt_o requests a new write.
REQ-023 A requester asserting continuously is guaranteed service within 4 transactions (12 cycles) of the current one completing.
REQ-024 No more than one gnt_o bit is high in any cycle; no gnt_o pulse without a preceding reg_load_o cycle.

Reset
REQ-025 While rst_i = 1: reg_load_o = 0, gnt_o = 0, rdata_o = 0, busy_o = 0, regardless of state.
REQ-026 After a rst_i edge: state = IDLE, ptr = 0, latched data = 0, latched winner = 0, reg_in_o = 0.
REQ-027 Reset in WRITE or ACK aborts the transaction; no gnt_o is issued for it; the Register write occurs only if WRITE completed before the reset cycle.
REQ-028 First IDLE cycle after reset deassertion arbitrates normally with priority 0>1>2>3.

Verification
REQ-029 Single request: req_i = 0001, data0 = 0x1234 -> reg_load_o = 1 with reg_in_o = 0x1234 one cycle later; gnt_o = 0001 and rdata_o = 0x1234 the next cycle.
REQ-030 All requesting: req_i = 1111 held, data n = 0xA000+n -> grants in order 0,1,2,3,0, each 3 cycles apart; Register sequence A000, A001, A002, A003.
REQ-031 Pointer wrap: after a grant to requester 3 with req_i = 1001 -> next grant goes to requester 0.
REQ-032 Late change: data1 changes from 0x0055 to 0x00AA in the WRITE cycle -> Register is loaded with 0x0055; requester drops req in ACK -> gnt_o = 0010 still pulses.
REQ-033 Reset mid-op: rst_i high in the ACK cycle -> gnt_o = 0 that cycle; state IDLE; with req_i = 0100 the next grant goes to requester 2 with ptr starting at 0.
REQ-034 Idle: req_i = 0 for 10 cycles -> reg_load_o, gnt_o, and busy_o stay 0; reg_in_o is unchanged.
